conv_mac_sched: RTL

Sequencer for one shared signed 16x8 -> 24-bit multiplier. Computes one convolution output per job: bias + sum of TAPS activation*weight products. Streams (activation, weight) pairs through a registered product stage into a wide accumulator, then rounds, shifts and saturates the sum to one output pixel. Sits between the line-buffer/weight-fetch stage and the output pixel FIFO of a conv layer.

---
 rtl/conv_mac_pkg.sv | 37 +++
 rtl/conv_mac_sched_if.sv | 34 +++
 rtl/conv_mul_16x8.sv | 11 +
 rtl/conv_mac_sched.sv | 110 +++++++++++
 4 files changed

// File: rtl/conv_mac_pkg.sv
// Shared types and helpers for the conv MAC sequencer.
// Multiplier widths, FSM encoding and the output round/saturate step.
package conv_mac_pkg;

  localparam int ACT_W  = 16;
  localparam int WGT_W  = 8;
  localparam int PROD_W = 24;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACC   = 2'd1,
    FLUSH = 2'd2,
    HOLD  = 2'd3
  } state_e;

  // Round half up, arithmetic shift, clamp to a signed ow-bit range.
  function automatic logic signed [63:0] rnd_sat(
    input logic signed [63:0] x,
    input int                 shift,
    input int                 ow
  );
    logic signed [63:0] r;
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    r = x;
    if (shift > 0)
      r = (x + (64'sd1 <<< (shift - 1))) >>> shift;
    hi = (64'sd1 <<< (ow - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    if (r > hi)
      r = hi;
    else if (r < lo)
      r = lo;
    return r;
  endfunction

endpackage

// File: rtl/conv_mac_sched_if.sv
// Job, pair-stream and result handshakes of the conv MAC sequencer.
// master drives jobs and pairs; slave is the sequencer.
interface conv_mac_sched_if #(
  parameter int ACC_WIDTH = 32,
  parameter int OUT_WIDTH = 16,
  parameter int TW        = 4
);
  logic                        start;
  logic signed [ACC_WIDTH-1:0] bias;
  logic                        in_valid;
  logic                        in_ready;
  logic signed [15:0]          in_act;
  logic signed [7:0]           in_wgt;
  logic                        out_valid;
  logic                        out_ready;
  logic signed [OUT_WIDTH-1:0] out_data;
  logic                        busy;
  logic                        done;
  logic [TW-1:0]               tap_count;

  modport master (
    output start, bias, in_valid,
    output in_act, in_wgt, out_ready,
    input  in_ready, out_valid, out_data,
    input  busy, done, tap_count
  );

  modport slave (
    input  start, bias, in_valid,
    input  in_act, in_wgt, out_ready,
    output in_ready, out_valid, out_data,
    output busy, done, tap_count
  );
endinterface

// File: rtl/conv_mul_16x8.sv
// Combinational signed 16x8 -> 24 multiplier.
// Kept bare so synthesis maps it onto a single DSP slice.
module conv_mul_16x8
  import conv_mac_pkg::*;
(
  input  logic signed [ACT_W-1:0]  i_a,
  input  logic signed [WGT_W-1:0]  i_w,
  output logic signed [PROD_W-1:0] o_p
);
  assign o_p = PROD_W'(i_a) * PROD_W'(i_w);
endmodule

// File: rtl/conv_mac_sched.sv
// Convolution MAC sequencer: bias + sum of TAPS products,
// then round, shift and saturate to one output pixel.
module conv_mac_sched
  import conv_mac_pkg::*;
#(
  parameter int TAPS      = 9,
  parameter int ACC_WIDTH = 32,
  parameter int SHIFT     = 8,
  parameter int OUT_WIDTH = 16
) (
  input  logic             ap_clk,
  input  logic             ap_rst_n,
  conv_mac_sched_if.slave  bus
);
  localparam int TW = $clog2(TAPS + 1);
  localparam logic [TW-1:0] LAST = TW'(TAPS - 1);

  generate
    if (ACC_WIDTH < PROD_W + $clog2(TAPS) + 1) begin : g_bad_acc
      $error("ACC_WIDTH too small for TAPS");
    end
  endgenerate

  state_e                      r_state;
  state_e                      w_nxt;
  logic signed [ACC_WIDTH-1:0] r_acc;
  logic signed [ACC_WIDTH-1:0] w_pext;
  logic signed [ACC_WIDTH-1:0] w_final;
  logic signed [PROD_W-1:0]    r_prod_q;
  logic signed [PROD_W-1:0]    w_prod;
  logic                        r_prod_v;
  logic [TW-1:0]               r_tap;
  logic signed [OUT_WIDTH-1:0] r_out;
  logic signed [63:0]          w_rs;
  logic                        w_in_ready;
  logic                        w_out_valid;
  logic                        w_fire;

  conv_mul_16x8 u_mul (
    .i_a (bus.in_act),
    .i_w (bus.in_wgt),
    .o_p (w_prod)
  );

  assign w_in_ready  = (r_state == ACC);
  assign w_out_valid = (r_state == HOLD);
  assign w_fire      = bus.in_valid & w_in_ready;

  assign w_pext = {{(ACC_WIDTH-PROD_W){r_prod_q[PROD_W-1]}},
                   r_prod_q};
  assign w_final = r_acc + w_pext;
  assign w_rs = rnd_sat(
    {{(64-ACC_WIDTH){w_final[ACC_WIDTH-1]}}, w_final},
    SHIFT, OUT_WIDTH);

  always_comb begin
    w_nxt = r_state;
    unique case (r_state)
      IDLE:  if (bus.start) w_nxt = ACC;
      ACC:   if (w_fire && r_tap == LAST) w_nxt = FLUSH;
      FLUSH: w_nxt = HOLD;
      HOLD:  if (bus.out_ready) w_nxt = IDLE;
      default: w_nxt = IDLE;
    endcase
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      r_state  <= IDLE;
      r_acc    <= '0;
      r_prod_q <= '0;
      r_prod_v <= 1'b0;
      r_tap    <= '0;
      r_out    <= '0;
    end else begin
      r_state <= w_nxt;
      unique case (r_state)
        IDLE: begin
          r_prod_v <= 1'b0;
          if (bus.start) begin
            r_acc <= bus.bias;
            r_tap <= '0;
          end
        end
        ACC: begin
          r_prod_v <= w_fire;
          if (w_fire) begin
            r_prod_q <= w_prod;
            r_tap    <= r_tap + 1'b1;
          end
          if (r_prod_v) r_acc <= w_final;
        end
        // The last product is always pending on entry here.
        FLUSH: begin
          r_prod_v <= 1'b0;
          r_acc    <= w_final;
          r_out    <= w_rs[OUT_WIDTH-1:0];
        end
        default: r_prod_v <= 1'b0;
      endcase
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = w_out_valid;
  assign bus.out_data  = r_out;
  assign bus.busy      = (r_state != IDLE);
  assign bus.done      = w_out_valid & bus.out_ready;
  assign bus.tap_count = r_tap;
endmodule
